// File: rtl/pa_f_spsram_256x4_ctrl_pkg.sv
// Shared definitions for the 256x4 single-port SRAM controller:
// controller states, default geometry and the idle levels of the macro pins.
package pa_f_spsram_256x4_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 4;

    // INIT only exists when the clear sweep is built in.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Idle levels of the active-low macro controls.
    localparam logic CEN_OFF     = 1'b1;
    localparam logic GWEN_OFF    = 1'b1;
    localparam logic WEN_OFF_BIT = 1'b1;

endpackage

// File: rtl/pa_f_spsram_rsp_buf.sv
// Read response path: tracks the single outstanding read, bypasses Q
// straight to the response port and parks it in a one-entry hold register
// when the consumer stalls.
module pa_f_spsram_rsp_buf
    import pa_f_spsram_256x4_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rd_fire,
    input  logic                  rsp_rdy,
    input  logic [DATA_WIDTH-1:0] Q,
    output logic                  rd_pend,
    output logic                  hold_vld,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_rdata
);

    logic [DATA_WIDTH-1:0] hold_q;

    // Control flags: a read is pending the cycle after it fires; a stalled
    // bypass response moves into the hold register until accepted.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        // NOTE: RST is sampled on CLK only; it never acts between edges.
        if (RST) begin
            rd_pend  <= 1'b0;
            hold_vld <= 1'b0;
        end else begin
            rd_pend <= rd_fire;
            if (rd_pend && !rsp_rdy) begin
                hold_vld <= 1'b1;
            end else if (rsp_rdy) begin
                hold_vld <= 1'b0;
            end
        end
    end

    // Hold data capture from Q when the bypass response is not accepted.
    always_ff @(posedge CLK) begin
        // NOTE: data register left unreset; it is only visible while hold_vld is set.
        if (rd_pend && !rsp_rdy) begin
            hold_q <= Q;
        end
    end

    // Response mux: hold register first, else live Q the cycle after the read.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        rsp_vld   = 1'b0;
        rsp_rdata = '0;
        if (!RST) begin
            if (hold_vld) begin
                rsp_vld   = 1'b1;
                rsp_rdata = hold_q;
            end else if (rd_pend) begin
                rsp_vld   = 1'b1;
                rsp_rdata = Q;
            end
        end
    end

endmodule

// File: rtl/pa_f_spsram_256x4_ctrl.sv
// Initiator-side controller for the 256x4 single-port SRAM macro.
// Requests on a valid/ready port drive the macro pins combinationally;
// read data returns through pa_f_spsram_rsp_buf.
// Build option PA_F_SPSRAM_INIT_EN: after reset, sweep zeros into every
// entry before accepting requests (init_done rises when the sweep ends).
module pa_f_spsram_256x4_ctrl
    import pa_f_spsram_256x4_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q
);

    localparam logic [DATA_WIDTH-1:0] WEN_IDLE = {DATA_WIDTH{WEN_OFF_BIT}};

    state_t state;
    logic   rd_pend;
    logic   hold_vld;
    logic   rd_fire;

`ifdef PA_F_SPSRAM_INIT_EN
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] sweep_cnt;

    // State register: reset always restarts the clear sweep.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Sweep address counter, advancing once per INIT cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sweep_cnt <= '0;
        end else if (state == ST_INIT) begin
            sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
        end
    end

    // Next state: leave INIT once the last address has been written.
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && sweep_cnt == {ADDR_WIDTH{1'b1}}) begin
            state_nxt = ST_RUN;
        end
    end
`else
    // Without the sweep the controller is ready as soon as reset drops.
    assign state = ST_RUN;
`endif

    // Output decode: sweep writes in INIT, request-driven pins in RUN.
    always_comb begin
        req_rdy   = 1'b0;
        init_done = 1'b0;
        CEN       = CEN_OFF;
        GWEN      = GWEN_OFF;
        WEN       = WEN_IDLE;
        A         = req_addr;
        D         = req_wdata;
        if (RST) begin
            A = '0;
            D = '0;
        end else begin
            case (state)
`ifdef PA_F_SPSRAM_INIT_EN
                ST_INIT: begin
                    CEN  = 1'b0;
                    GWEN = 1'b0;
                    WEN  = '0;
                    D    = '0;
                    A    = sweep_cnt;
                end
`endif
                ST_RUN: begin
                    init_done = 1'b1;
                    // A stalled response blocks new requests so only one
                    // read is ever in flight.
                    req_rdy   = !hold_vld && !(rd_pend && !rsp_rdy);
                    if (req_vld && req_rdy) begin
                        CEN = 1'b0;
                        if (req_wr) begin
                            GWEN = 1'b0;
                            WEN  = ~req_wmask;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_fire = req_vld && req_rdy && !req_wr;

    pa_f_spsram_rsp_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_buf (
        .CLK       (CLK),
        .RST       (RST),
        .rd_fire   (rd_fire),
        .rsp_rdy   (rsp_rdy),
        .Q         (Q),
        .rd_pend   (rd_pend),
        .hold_vld  (hold_vld),
        .rsp_vld   (rsp_vld),
        .rsp_rdata (rsp_rdata)
    );

endmodule
